// File: rtl/y86_pkg.sv
// Shared Y86-64 constants used by the fetch queue and by fetch/decode.
package y86_pkg;

    localparam int Y86_ADDR_W     = 64;
    localparam int INSN_MAX_BYTES = 10;
    localparam int MEM_RD_BYTES   = 8;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/fq_byte_ring.sv
// Byte-granular ring storage: one 8-byte write port at tail, one 10-byte read window at head.
module fq_byte_ring
    import y86_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [MEM_RD_BYTES*8-1:0]     wr_data,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [INSN_MAX_BYTES*8-1:0]   rd_bytes
);

    logic [7:0] mem [DEPTH];

    // Index sums wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < MEM_RD_BYTES; i++) begin
                mem[wr_idx + IDX_W'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_bytes = '0;
        for (int i = 0; i < INSN_MAX_BYTES; i++) begin
            rd_bytes[8*i +: 8] = mem[rd_idx + IDX_W'(i)];
        end
    end

endmodule

// File: rtl/y86_fetch_queue.sv
// Instruction prefetch queue: sequential 8-byte memory reads feed a byte ring,
// fetch sees the next up-to-10 bytes; redirect flushes and drops in-flight data.
module y86_fetch_queue
    import y86_pkg::*;
#(
    parameter int                ADDR_W   = Y86_ADDR_W,
    parameter int                DEPTH    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [ADDR_W-1:0]           req_addr,
    input  logic                        resp_valid,
    input  logic [63:0]                 resp_data,
    input  logic                        resp_err,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [INSN_MAX_BYTES*8-1:0] out_bytes,
    output logic [3:0]                  out_count,
    output logic                        out_err,
    input  logic                        consume,
    input  logic [3:0]                  consume_len
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] FILL_LIMIT = PTR_W'(DEPTH - MEM_RD_BYTES);

    logic [PTR_W-1:0]  head, tail, occ;
    logic [ADDR_W-1:0] fetch_addr;
    logic              outstanding, discard, err;
    logic              resp_take, resp_write, consume_ok;
    logic [INSN_MAX_BYTES*8-1:0] ring_bytes;

    // Memory handshake: a read transfers on any edge where req_valid && req_ready;
    // req_addr is stable while req_valid is high. resp_valid is a one-cycle pulse
    // with no backpressure and is only meaningful while a read is outstanding.
    assign occ       = tail - head;
    assign req_valid = !rst && !outstanding && !err && !redirect && (occ <= FILL_LIMIT);
    assign req_addr  = fetch_addr;

    assign out_count  = (occ >= PTR_W'(INSN_MAX_BYTES)) ? 4'(INSN_MAX_BYTES) : occ[3:0];
    assign out_err    = err;
    assign resp_take  = resp_valid && outstanding;
    assign resp_write = resp_take && !discard && !resp_err && !redirect && !rst;
    assign consume_ok = consume && (consume_len != 4'd0) && (consume_len <= out_count);

    always_comb begin
        out_bytes = '0;
        for (int i = 0; i < INSN_MAX_BYTES; i++) begin
            if (4'(i) < out_count) out_bytes[8*i +: 8] = ring_bytes[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            fetch_addr  <= RESET_PC;
            out_pc      <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            err         <= 1'b0;
        end else if (redirect) begin
            head        <= '0;
            tail        <= '0;
            fetch_addr  <= redirect_pc;
            out_pc      <= redirect_pc;
            err         <= 1'b0;
            // A response landing in this very cycle is the stale one.
            outstanding <= outstanding && !resp_valid;
            discard     <= outstanding && !resp_valid;
        end else begin
            if (req_valid && req_ready) outstanding <= 1'b1;
            if (resp_take) begin
                outstanding <= 1'b0;
                if (discard) begin
                    discard <= 1'b0;
                end else if (resp_err) begin
                    err <= 1'b1;
                end else begin
                    tail       <= tail + PTR_W'(MEM_RD_BYTES);
                    fetch_addr <= fetch_addr + ADDR_W'(MEM_RD_BYTES);
                end
            end
            if (consume_ok) begin
                head   <= head + PTR_W'(consume_len);
                out_pc <= out_pc + ADDR_W'(consume_len);
            end
        end
    end

    fq_byte_ring #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ring (
        .clk      (clk),
        .wr_en    (resp_write),
        .wr_idx   (tail[IDX_W-1:0]),
        .wr_data  (resp_data),
        .rd_idx   (head[IDX_W-1:0]),
        .rd_bytes (ring_bytes)
    );

endmodule

// File: tb/tb_y86_fetch_queue.sv
// Directed plus randomized bench for y86_fetch_queue against a byte-queue reference model.
module tb_y86_fetch_queue;

    localparam int          DEPTH  = 32;
    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        resp_valid, resp_err;
    logic [63:0] resp_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] out_pc;
    logic [79:0] out_bytes;
    logic [3:0]  out_count;
    logic        out_err;
    logic        consume;
    logic [3:0]  consume_len;

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes in program order plus fetch bookkeeping.
    logic [7:0]  mq[$];
    logic [63:0] m_pc, m_fetch;
    bit          m_out, m_disc, m_err;

    // Memory responder state.
    bit          mem_pend;
    int          mem_wait;
    logic [63:0] mem_addr;
    bit          err_next;
    bit          ready_now;
    int          lat_now;
    bit          spur;
    int          req_seen;
    logic [63:0] last_req_addr;

    always #5 clk = ~clk;

    y86_fetch_queue #(
        .ADDR_W   (64),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_pc      (out_pc),
        .out_bytes   (out_bytes),
        .out_count   (out_count),
        .out_err     (out_err),
        .consume     (consume),
        .consume_len (consume_len)
    );

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0];
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
        return w;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        logic [79:0] exp_b;
        n = (mq.size() < 10) ? mq.size() : 10;
        exp_b = '0;
        for (int i = 0; i < n; i++) exp_b[8*i +: 8] = mq[i];
        chk("out_count", 80'(out_count), 80'(n));
        chk("out_bytes", out_bytes, exp_b);
        chk("out_pc", 80'(out_pc), 80'(m_pc));
        chk("out_err", 80'(out_err), 80'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; consume = 1'b0; consume_len = 4'd0;
        resp_valid = 1'b0; resp_err = 1'b0; req_ready = 1'b1;
        #1;
        chk("req_valid_in_rst", 80'(req_valid), 80'(0));
        @(posedge clk); #1;
        mq.delete();
        m_pc = RST_PC; m_fetch = RST_PC;
        m_out = 1'b0; m_disc = 1'b0; m_err = 1'b0;
        check_outputs();
        rst = 1'b0;
    endtask

    // One clock: drive inputs, check request side, advance model, check outputs after the edge.
    task automatic tick(input bit c, input int len, input bit r, input logic [63:0] rpc);
        int n;
        bit acc, hit, exp_rv;
        consume = c; consume_len = 4'(len); redirect = r; redirect_pc = rpc;
        req_ready = ready_now;
        resp_valid = (mem_pend && mem_wait == 0) || (!mem_pend && spur);
        resp_data = mem_word(mem_addr);
        resp_err = resp_valid && err_next;
        #1;
        exp_rv = !m_out && !m_err && !r && ((DEPTH - mq.size()) >= 8);
        chk("req_valid", 80'(req_valid), 80'(exp_rv));
        if (exp_rv) chk("req_addr", 80'(req_addr), 80'(m_fetch));

        acc = exp_rv && req_ready;
        hit = resp_valid && m_out;
        n = (mq.size() < 10) ? mq.size() : 10;
        if (r) begin
            mq.delete();
            m_pc = rpc; m_fetch = rpc; m_err = 1'b0;
            m_disc = m_out && !resp_valid;
            m_out  = m_out && !resp_valid;
        end else begin
            if (c && len >= 1 && len <= n) begin
                repeat (len) void'(mq.pop_front());
                m_pc = m_pc + 64'(len);
            end
            if (hit) begin
                m_out = 1'b0;
                if (m_disc) m_disc = 1'b0;
                else if (resp_err) m_err = 1'b1;
                else begin
                    for (int i = 0; i < 8; i++) mq.push_back(mem_byte(m_fetch + 64'(i)));
                    m_fetch = m_fetch + 64'd8;
                end
            end
            if (acc) m_out = 1'b1;
        end

        if (resp_valid && mem_pend) begin
            mem_pend = 1'b0;
            if (resp_err) err_next = 1'b0;
        end else if (mem_pend) begin
            mem_wait--;
        end
        if (req_valid && req_ready) begin
            mem_pend = 1'b1; mem_addr = req_addr; mem_wait = lat_now;
            req_seen++; last_req_addr = req_addr;
        end
        @(posedge clk); #1;
        check_outputs();
    endtask

    initial begin
        mem_pend = 0; mem_wait = 0; mem_addr = '0; err_next = 0; spur = 0;
        ready_now = 1; lat_now = 0; req_seen = 0; last_req_addr = '0;
        redirect_pc = '0; resp_data = '0;
        @(posedge clk); #1;
        do_reset();
        do_reset();

        // First fill from RESET_PC.
        repeat (2) tick(0, 0, 0, '0);
        chk("first_count", 80'(out_count), 80'(8));
        chk("first_byte0", 80'(out_bytes[7:0]), 80'(8'h00));
        chk("first_pc", 80'(out_pc), 80'(64'h100));
        chk("first_req_addr", 80'(last_req_addr), 80'(64'h100));

        tick(1, 3, 0, '0);
        chk("pc_after_3", 80'(out_pc), 80'(64'h103));
        tick(0, 0, 0, '0);
        tick(1, 10, 0, '0);
        chk("pc_after_10", 80'(out_pc), 80'(64'h10D));

        // Fill to capacity, wrapping the ring.
        repeat (8) tick(0, 0, 0, '0);
        tick(1, 3, 0, '0);
        repeat (2) tick(0, 0, 0, '0);
        req_seen = 0;
        repeat (4) tick(0, 0, 0, '0);
        chk("full_no_req", 80'(req_seen), 80'(0));
        tick(1, 8, 0, '0);
        repeat (4) tick(0, 0, 0, '0);
        chk("one_req_after_8", 80'(req_seen), 80'(1));

        // Redirect while a read is in flight: stale data must vanish.
        lat_now = 3;
        tick(0, 0, 1, 64'h200);
        tick(0, 0, 0, '0);
        tick(0, 0, 1, 64'h400);
        repeat (3) tick(0, 0, 0, '0);
        chk("stale_dropped", 80'(out_count), 80'(0));
        tick(0, 0, 0, '0);
        chk("redirect_req_addr", 80'(last_req_addr), 80'(64'h400));
        repeat (4) tick(0, 0, 0, '0);
        chk("redirect_fill", 80'(out_count), 80'(8));

        // Fault on the second read.
        lat_now = 0;
        tick(0, 0, 1, 64'h800);
        repeat (2) tick(0, 0, 0, '0);
        err_next = 1;
        repeat (2) tick(0, 0, 0, '0);
        req_seen = 0;
        repeat (3) tick(0, 0, 0, '0);
        chk("err_set", 80'(out_err), 80'(1));
        chk("err_no_req", 80'(req_seen), 80'(0));
        chk("err_bytes_kept", 80'(out_count), 80'(8));
        tick(1, 8, 0, '0);
        chk("err_consume_pc", 80'(out_pc), 80'(64'h808));
        tick(0, 0, 1, 64'h900);
        chk("err_cleared", 80'(out_err), 80'(0));

        // Response and consume of 5 together at occupancy 6.
        tick(0, 0, 1, 64'h600);
        repeat (2) tick(0, 0, 0, '0);
        tick(1, 2, 0, '0);
        tick(1, 5, 0, '0);
        chk("same_cycle_count", 80'(out_count), 80'(9));
        chk("same_cycle_pc", 80'(out_pc), 80'(64'h607));

        // Randomized traffic, with a reset in the middle of it.
        for (int k = 0; k < 800; k++) begin
            logic [63:0] rpc;
            ready_now = ($urandom_range(0, 3) != 0);
            lat_now   = $urandom_range(0, 3);
            spur      = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 24) == 0) err_next = 1;
            rpc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31)))
                                              : {$urandom, $urandom};
            if (k == 400) do_reset();
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 12), $urandom_range(0, 39) == 0, rpc);
        end
        spur = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
